reverb_tap_sequencer: RTL and testbench
=======================================

Name: reverb_tap_sequencer

Overview:
Configuration controller that owns the reverb datapath's FIR tap interface and its enable/bypass controls. Software writes a complete tap set into a local shadow RAM, then issues an apply command. The block then:
- forces the datapath into bypass so audio keeps passing,
- drains the pipeline,
- flushes the datapath with an enable-low pulse,
- streams all taps into the FIR load port,
- waits for the FIR load-done, then releases bypass.

Sits between the register/control bus and the reverb wrapper.

Parameters:
G_NUM_STAGES_LOG2, 2, FIR stage count log2; must match datapath
G_STAGE_DEPTH_LOG2, 2, FIR stage depth log2; must match datapath
G_TAP_WIDTH, 16, tap word width
G_DRAIN_CYCLES, 16, cycles to hold bypass before flushing (>=1)
G_DONE_TIMEOUT, 1024, max cycles from last tap accepted to tap_done
Derived: N = 2**(G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2) taps; AW = G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
cfg_wr_en  in  1  shadow RAM write strobe
cfg_wr_addr  in  AW  shadow RAM tap index
cfg_wr_data  in  G_TAP_WIDTH  tap value
cfg_wr_ready  out  1  high when shadow writes are accepted
apply  in  1  single-cycle request to load the shadow taps
busy  out  1  high in any state other than IDLE/RUN
load_count  out  16  number of completed loads, wraps
error  out  1  sticky timeout flag; cleared by the next accepted apply
dp_enable  out  1  drives datapath enable
dp_bypass  out  1  drives datapath bypass
tap_dout  out  G_TAP_WIDTH  tap word to FIR
tap_dout_valid  out  1  tap word valid
tap_dout_ready  in  1  FIR ready for tap
tap_done  in  1  FIR reports all taps loaded

Behaviour:
- Reset values (reset==0 at a clk edge):
  - state=IDLE, dp_enable=0, dp_bypass=1, tap_dout_valid=0, tap_dout=0, busy=0, error=0, load_count=0, pending=0.
  - cfg_wr_ready=1. Shadow RAM contents are not reset.
- Reset mid-operation takes effect on the next edge from any state. No further taps are issued.
- Shadow RAM:
  - N x G_TAP_WIDTH, written when cfg_wr_en & cfg_wr_ready.
  - cfg_wr_ready=0 in FLUSH and LOAD; writes in those states are dropped.
- FSM states:
  - IDLE: no valid taps loaded; dp_enable=0, dp_bypass=1. apply -> DRAIN.
  - DRAIN: dp_enable=1, dp_bypass=1. Counter counts G_DRAIN_CYCLES cycles -> FLUSH.
  - FLUSH: exactly 1 cycle with dp_enable=0, dp_bypass=1. This clears the datapath buffers and the FIR tap counter. -> LOAD with tap index=0.
  - LOAD: dp_enable=1, dp_bypass=1.
    - tap_dout = shadow[index], tap_dout_valid=1.
    - Each cycle with valid&ready: index++.
    - tap_dout/tap_dout_valid are registered outputs. RAM read is prefetched so back-to-back transfers sustain 1 tap/cycle while ready stays high.
    - Data must hold stable while valid&!ready.
    - After the handshake of index N-1: valid=0 the next cycle -> WAIT_DONE.
  - WAIT_DONE: dp_bypass=1. Timeout counter starts at 0.
    - tap_done==1 -> RUN; load_count++.
    - Counter reaching G_DONE_TIMEOUT -> IDLE with error=1.
    - tap_done already high on the cycle of entry counts as done.
  - RUN: dp_enable=1, dp_bypass=0 (first cycle after tap_done seen). apply -> DRAIN.
- apply handling:
  - apply in DRAIN/FLUSH/LOAD/WAIT_DONE sets pending; it is not a restart.
  - On entry to RUN or IDLE with pending=1: pending clears and the FSM goes to DRAIN on the next cycle. In the RUN case, dp_bypass is not released in that cycle; the bypass stays high.
  - Multiple applies while busy collapse to one pending request.
  - apply and reset together: reset wins.
- busy = state in {DRAIN, FLUSH, LOAD, WAIT_DONE}.
- dp_bypass deasserts only in RUN. It is never low in the cycle where dp_enable is low.
- No arithmetic beyond the counters. Index counter is AW+1 bits to detect end. Timeout counter width = clog2(G_DONE_TIMEOUT+1).

Test Plan:
1. Reset, write taps k*0x0101 for k=0..15, pulse apply, hold tap_dout_ready=1, tap_done 2 cycles after the last tap.
   -> dp_bypass=1 from reset; FLUSH is a single dp_enable=0 cycle after 16 DRAIN cycles; taps appear as 0x0000..0x0F0F in 16 consecutive cycles; dp_bypass=0 one cycle after tap_done; load_count=1.
2. Random tap_dout_ready backpressure (50%) during LOAD.
   -> exactly 16 handshakes, in order, no duplicates; tap_dout stable while valid&!ready.
3. Apply pulsed 3 times during LOAD.
   -> after the first load completes, exactly one further DRAIN/FLUSH/LOAD sequence; dp_bypass never drops between the two loads; load_count=2.
4. tap_done held low after the last tap with G_DONE_TIMEOUT=1024.
   -> IDLE after 1024 cycles in WAIT_DONE, error=1, dp_bypass=1; the next apply clears error and a successful load gives RUN.
5. cfg_wr_en to address 3 during LOAD (value 0xBEEF), then a second apply.
   -> cfg_wr_ready=0 and the write is dropped; the second load still emits the original shadow[3].
6. reset=0 asserted for 1 cycle at tap index 7 of LOAD.
   -> next cycle: tap_dout_valid=0, state IDLE, dp_bypass=1, dp_enable=0, load_count=0.

Source files
------------

// File: rtl/reverb_tap_sequencer.sv
// Reverb FIR tap-load sequencer: holds the datapath in bypass, drains it, flushes it,
// streams the shadow tap set into the FIR load port, then releases bypass once the FIR reports done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no valid tap set loaded; datapath disabled and bypassed
// DRAIN     | datapath enabled but bypassed while the pipeline empties
// FLUSH     | single enable-low cycle that clears the datapath buffers
// LOAD      | streaming shadow[0..N-1] into the FIR tap port
// WAIT_DONE | all taps sent; waiting for tap_done or the timeout
// RUN       | taps live; bypass released unless a reload is pending
module reverb_tap_sequencer #(
  parameter int G_NUM_STAGES_LOG2  = 2,
  parameter int G_STAGE_DEPTH_LOG2 = 2,
  parameter int G_TAP_WIDTH        = 16,
  parameter int G_DRAIN_CYCLES     = 16,
  parameter int G_DONE_TIMEOUT     = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          cfg_wr_en,
  input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]                        cfg_wr_data,
  output logic                                          cfg_wr_ready,
  input  logic                                          apply,
  output logic                                          busy,
  output logic [15:0]                                   load_count,
  output logic                                          error,
  output logic                                          dp_enable,
  output logic                                          dp_bypass,
  output logic [G_TAP_WIDTH-1:0]                        tap_dout,
  output logic                                          tap_dout_valid,
  input  logic                                          tap_dout_ready,
  input  logic                                          tap_done
);
  localparam int AW = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
  localparam int N  = 2 ** AW;
  localparam int DW = $clog2(G_DRAIN_CYCLES + 1);
  localparam int TW = $clog2(G_DONE_TIMEOUT + 1);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(N - 1);
  localparam logic [DW-1:0] DRAIN_TOP = DW'(G_DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(G_DONE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_FLUSH, S_LOAD, S_WAIT_DONE, S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic                   error_q, error_d;
  logic [15:0]            load_count_q, load_count_d;
  logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [AW:0]            idx_q, idx_d;
  logic [G_TAP_WIDTH-1:0] tap_dout_q, tap_dout_d;
  logic                   tap_valid_q, tap_valid_d;
  logic [G_TAP_WIDTH-1:0] shadow_q [N];
  logic [AW-1:0]          rd_addr;

  assign busy           = (state_q == S_DRAIN) || (state_q == S_FLUSH) ||
                          (state_q == S_LOAD)  || (state_q == S_WAIT_DONE);
  assign cfg_wr_ready   = (state_q != S_FLUSH) && (state_q != S_LOAD);
  assign dp_enable      = (state_q != S_IDLE) && (state_q != S_FLUSH);
  // A reload queued during the previous load keeps bypass up through RUN.
  assign dp_bypass      = !((state_q == S_RUN) && !pending_q);
  assign error          = error_q;
  assign load_count     = load_count_q;
  assign tap_dout       = tap_dout_q;
  assign tap_dout_valid = tap_valid_q;
  assign rd_addr        = idx_q[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (cfg_wr_en && cfg_wr_ready) shadow_q[cfg_wr_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
      load_count_q <= '0;
      drain_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      idx_q        <= '0;
      tap_dout_q   <= '0;
      tap_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
      load_count_q <= load_count_d;
      drain_cnt_q  <= drain_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      idx_q        <= idx_d;
      tap_dout_q   <= tap_dout_d;
      tap_valid_q  <= tap_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (apply & busy);
    error_d      = error_q;
    load_count_d = load_count_q;
    drain_cnt_d  = drain_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    idx_d        = idx_q;
    tap_dout_d   = tap_dout_q;
    tap_valid_d  = tap_valid_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (apply || pending_q) begin
          state_d     = S_DRAIN;
          pending_d   = 1'b0;
          error_d     = 1'b0;
          drain_cnt_d = DRAIN_TOP;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_FLUSH;
        else                   drain_cnt_d = drain_cnt_q - DW'(1);
      end
      S_FLUSH: begin
        state_d     = S_LOAD;
        idx_d       = '0;
        tap_dout_d  = shadow_q[0];
        tap_valid_d = 1'b1;
      end
      S_LOAD: begin
        // Next word is fetched on the handshake so ready-high sustains one tap per cycle.
        if (tap_valid_q && tap_dout_ready) begin
          if (idx_q == LAST_IDX) begin
            tap_valid_d = 1'b0;
            tmo_cnt_d   = '0;
            state_d     = S_WAIT_DONE;
          end else begin
            idx_d      = idx_q + (AW+1)'(1);
            tap_dout_d = shadow_q[rd_addr];
          end
        end
      end
      S_WAIT_DONE: begin
        if (tap_done) begin
          state_d      = S_RUN;
          load_count_d = load_count_q + 16'd1;
        end else if (tmo_cnt_q + TW'(1) == TMO_LIMIT) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reverb_tap_sequencer.sv
// Directed bench for reverb_tap_sequencer: tap streaming, backpressure, queued applies,
// done timeout, dropped shadow writes and mid-load reset.
module tb_reverb_tap_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [15:0] cfg_wr_data = '0;
  logic        cfg_wr_ready;
  logic        apply = 1'b0;
  logic        busy;
  logic [15:0] load_count;
  logic        error;
  logic        dp_enable;
  logic        dp_bypass;
  logic [15:0] tap_dout;
  logic        tap_dout_valid;
  logic        tap_dout_ready = 1'b1;
  logic        tap_done = 1'b0;

  int checks = 0;
  int failures = 0;

  int drain_len, flush_len, n_hs, ncyc, stable_err, byp_low, rst_hit, wcnt, bad;
  logic        wr_rdy_seen;
  logic [15:0] got [16];

  reverb_tap_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ready(cfg_wr_ready), .apply(apply), .busy(busy), .load_count(load_count),
    .error(error), .dp_enable(dp_enable), .dp_bypass(dp_bypass),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready), .tap_done(tap_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_bad_taps();
    int b = 0;
    for (int k = 0; k < 16; k++)
      if (got[k] !== 16'(k * 16'h0101)) b++;
    return b;
  endfunction

  // Optionally pulses apply, then observes DRAIN, FLUSH and LOAD, recording each handshake.
  task automatic load_phase(input bit do_apply, input bit bp, input bit apl3,
                            input bit wr3, input bit rst7);
    bit          rdy;
    bit          prev_stall;
    logic [15:0] prev_dout;
    drain_len = 0; flush_len = 0; n_hs = 0; ncyc = 0;
    stable_err = 0; byp_low = 0; rst_hit = 0; wr_rdy_seen = 1'b1;
    tap_dout_ready = 1'b1;
    apply = do_apply;
    tick();
    apply = 1'b0;
    while (dp_enable === 1'b1 && tap_dout_valid !== 1'b1 && drain_len < 100) begin
      if (dp_bypass !== 1'b1) byp_low++;
      drain_len++;
      tick();
    end
    while (dp_enable === 1'b0 && busy === 1'b1 && flush_len < 100) begin
      if (dp_bypass !== 1'b1) byp_low++;
      flush_len++;
      tick();
    end
    prev_stall = 1'b0;
    prev_dout  = '0;
    while (n_hs < 16 && ncyc < 300) begin
      if (dp_bypass !== 1'b1) byp_low++;
      if (prev_stall && tap_dout !== prev_dout) stable_err++;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tap_dout_ready = rdy;
      apply = apl3 && (ncyc == 2 || ncyc == 5 || ncyc == 9);
      cfg_wr_en   = wr3 && (ncyc == 1);
      cfg_wr_addr = 4'd3;
      cfg_wr_data = 16'hBEEF;
      if (wr3 && ncyc == 1) wr_rdy_seen = cfg_wr_ready;
      if (rst7 && n_hs == 7 && tap_dout_valid === 1'b1) begin
        reset = 1'b0;
        tick();
        rst_hit = 1;
        break;
      end
      if (tap_dout_valid === 1'b1 && rdy) begin
        got[n_hs] = tap_dout;
        n_hs++;
      end
      prev_stall = (tap_dout_valid === 1'b1) && !rdy;
      prev_dout  = tap_dout;
      ncyc++;
      tick();
    end
    apply = 1'b0;
    cfg_wr_en = 1'b0;
    tap_dout_ready = 1'b1;
  endtask

  // Called at the first WAIT_DONE cycle: raises tap_done one cycle later, stops one cycle into RUN.
  task automatic finish_done();
    tick();
    tap_done = 1'b1;
    chk("bypass_held_at_done", 32'(dp_bypass), 32'd1);
    tick();
    tap_done = 1'b0;
  endtask

  initial begin
    tick(); tick(); tick();
    chk("rst_bypass", 32'(dp_bypass), 32'd1);
    chk("rst_enable", 32'(dp_enable), 32'd0);
    chk("rst_valid", 32'(tap_dout_valid), 32'd0);
    chk("rst_dout", 32'(tap_dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_wr_ready", 32'(cfg_wr_ready), 32'd1);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'(k); cfg_wr_data = 16'(k * 16'h0101);
      tick();
    end
    cfg_wr_en = 1'b0;

    // 1: plain load with ready held high
    load_phase(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_drain_len", 32'(drain_len), 32'd16);
    chk("t1_flush_len", 32'(flush_len), 32'd1);
    chk("t1_handshakes", 32'(n_hs), 32'd16);
    chk("t1_load_cycles", 32'(ncyc), 32'd16);
    chk("t1_bad_taps", 32'(count_bad_taps()), 32'd0);
    chk("t1_bypass_low", 32'(byp_low), 32'd0);
    chk("t1_valid_after_last", 32'(tap_dout_valid), 32'd0);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    finish_done();
    chk("t1_bypass_run", 32'(dp_bypass), 32'd0);
    chk("t1_enable_run", 32'(dp_enable), 32'd1);
    chk("t1_load_count", 32'(load_count), 32'd1);

    // 2: random backpressure
    load_phase(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_handshakes", 32'(n_hs), 32'd16);
    chk("t2_bad_taps", 32'(count_bad_taps()), 32'd0);
    chk("t2_unstable", 32'(stable_err), 32'd0);
    finish_done();
    chk("t2_load_count", 32'(load_count), 32'd2);

    // 3: three applies during LOAD collapse into one reload
    load_phase(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_first_handshakes", 32'(n_hs), 32'd16);
    finish_done();
    chk("t3_bypass_pending_run", 32'(dp_bypass), 32'd1);
    chk("t3_busy_pending_run", 32'(busy), 32'd0);
    chk("t3_first_load_count", 32'(load_count), 32'd3);
    load_phase(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_second_drain_len", 32'(drain_len), 32'd16);
    chk("t3_second_flush_len", 32'(flush_len), 32'd1);
    chk("t3_second_bad_taps", 32'(count_bad_taps()), 32'd0);
    chk("t3_bypass_low", 32'(byp_low), 32'd0);
    finish_done();
    chk("t3_bypass_run", 32'(dp_bypass), 32'd0);
    chk("t3_load_count", 32'(load_count), 32'd4);
    tick(); tick(); tick();
    chk("t3_no_third_load", 32'(busy), 32'd0);

    // 4: tap_done never arrives
    load_phase(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wcnt = 0;
    while (busy === 1'b1 && wcnt < 2000) begin
      wcnt++;
      tick();
    end
    chk("t4_wait_cycles", 32'(wcnt), 32'd1024);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_bypass_idle", 32'(dp_bypass), 32'd1);
    chk("t4_enable_idle", 32'(dp_enable), 32'd0);
    chk("t4_load_count_hold", 32'(load_count), 32'd4);
    load_phase(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_error_cleared", 32'(error), 32'd0);
    finish_done();
    chk("t4_bypass_run", 32'(dp_bypass), 32'd0);
    chk("t4_load_count", 32'(load_count), 32'd5);

    // 5: shadow write during LOAD is dropped
    load_phase(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_wr_ready_in_load", 32'(wr_rdy_seen), 32'd0);
    finish_done();
    chk("t5_load_count", 32'(load_count), 32'd6);
    load_phase(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_tap3", 32'(got[3]), 32'h0303);
    chk("t5_bad_taps", 32'(count_bad_taps()), 32'd0);
    finish_done();
    chk("t5_load_count2", 32'(load_count), 32'd7);

    // 6: reset pulse at tap index 7
    load_phase(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_reset_hit", 32'(rst_hit), 32'd1);
    chk("t6_valid", 32'(tap_dout_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_enable", 32'(dp_enable), 32'd0);
    chk("t6_bypass", 32'(dp_bypass), 32'd1);
    chk("t6_load_count", 32'(load_count), 32'd0);
    reset = 1'b1;
    tick(); tick();
    chk("t6_no_more_taps", 32'(tap_dout_valid), 32'd0);
    chk("t6_stays_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
